megaram_ram_arbiter: RTL and testbench
======================================

# megaram_ram_arbiter

Shares the single cartridge-RAM memory port between the two MegaRAM/ASCII/SCC mapper instances (slot 1, slot 2) and the ROM/RAM image loader. Each requester presents a held request (address, read/write, write data). The arbiter grants one request at a time, runs a req/ack transaction on the memory port and returns read data with a one-cycle acknowledge. It sits between the mapper `out.addr/ram_cs/rnw` outputs and the SDRAM controller front end.

## Interface
Parameters:
- `ADDR_W`, 27: requester/memory address width (matches mapper `out.addr`).
- `TIMEOUT`, 255: watchdog limit in clocks for one memory transaction (used only with the timeout feature).

Ports (requester index r: 0 = loader, 1 = slot 1 mapper, 2 = slot 2 mapper):
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req[3]`  in  1 each  request; held high until the matching `ack` pulse.
- `addr[3]`  in  ADDR_W each  byte address; stable while `req` is high.
- `rnw[3]`  in  1 each  1 = read, 0 = write; stable while `req` is high.
- `wdata[3]`  in  8 each  write data; stable while `req` is high.
- `ack[3]`  out  1 each  one-cycle completion pulse.
- `rdata`  out  8  read data, valid in the `ack` cycle and held until the next completion.
- `mem_req`  out  1  memory request level.
- `mem_addr`  out  ADDR_W  latched address.
- `mem_rnw`  out  1  latched direction.
- `mem_wdata`  out  8  latched write data.
- `mem_ack`  in  1  memory completion strobe (one cycle); `mem_rdata` is valid with it.
- `mem_rdata`  in  8  memory read data.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky timeout flag; tied 0 without the timeout feature.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any `req` is high, select a winner:
    - loader (0) has absolute priority;
    - otherwise round-robin between slot 1 and slot 2 using `last_slot`, which holds the slot served most recently.
  - Latch `addr`, `rnw` and `wdata` of the winner into the `mem_*` registers. Store the winner index in `gnt`. Go to ISSUE.
- **ISSUE**: assert `mem_req`. Go to WAIT.
- **WAIT**
  - Hold `mem_req` high until `mem_ack`.
  - On `mem_ack`: drop `mem_req`; if the access is a read, capture `mem_rdata` into `rdata`; go to DONE.
- **DONE**
  - `ack[gnt]` is high for exactly this cycle.
  - If `gnt` is 1 or 2, update `last_slot`.
  - Go to IDLE.
- Requesters deassert `req` at the clock edge on which they sample `ack`. IDLE in the following cycle therefore never re-serves the same request.
- Starvation bound: with the loader idle, a pending slot request waits at most one other slot transaction.
- A `req` that drops before being granted is ignored. A `req` that drops after being granted does not abort the transaction; `ack` is still pulsed.
- Writes leave `rdata` unchanged.

## Timing
- Reset state:
  - FSM = IDLE;
  - `mem_req`, `ack`, `busy`, `err` = 0;
  - `rdata` = 8'hFF;
  - `mem_addr` = all ones;
  - `mem_rnw` = 1;
  - `mem_wdata` = 0;
  - `last_slot` = slot 2, so slot 1 wins the first contested grant.
- With `req` rising at edge T:
  - grant latched at T+1;
  - `mem_req` high from T+2;
  - `mem_ack` at edge M gives `ack` high during cycle M+1.
- Minimum request-to-ack latency: 4 clocks when `mem_ack` returns one cycle after `mem_req`.
- Back-to-back throughput: one transaction per (memory latency + 3) clocks.
- `mem_req` is a registered level and is never deasserted before `mem_ack`.
- `mem_ack` received outside WAIT is ignored.
- Asserting `reset_n` low in any state forces the reset state immediately. The memory side must treat `mem_req` falling as an abort.

## Configuration
- Macro: `MEGARAM_ARB_TIMEOUT_EN`.
- Defined:
  - an 8-bit-wide-or-larger counter (`$clog2(TIMEOUT+1)` bits) clears on entry to WAIT and increments each WAIT cycle;
  - when it reaches `TIMEOUT` with no `mem_ack`: drop `mem_req`, set `rdata` = 8'hFF for reads, set sticky `err`, go to DONE so the requester still receives `ack`;
  - `err` clears only on reset.
- Undefined: no counter; WAIT waits indefinitely; `err` is constant 0.

## Structure
- Shared package `megaram_arb_pkg`:
  - typedef `arb_state_t` enum {IDLE, ISSUE, WAIT, DONE};
  - localparams `REQ_LOADER`=0, `REQ_SLOT1`=1, `REQ_SLOT2`=2, `N_REQ`=3;
  - typedef `req_idx_t` (2 bits).
- One sub-module, `megaram_arb_pick`: combinational winner selection. Inputs `req`, `last_slot`; outputs `valid`, `idx`. It is reusable if a fourth requester is added.
- Everything else stays in `megaram_ram_arbiter`.

## Test plan
- Single read:
  - stimulus: reset, then `req[1]` with `addr`=27'h0012345, `rnw`=1; memory returns 8'hA5 one cycle after `mem_req`;
  - required: `mem_addr`=27'h0012345, `ack[1]` 4 clocks after the `req` edge, `rdata`=8'hA5.
- Write then read:
  - stimulus: `req[2]` write 8'h3C to 27'h0100000, then read of the same address;
  - required: `mem_rnw`=0 and `mem_wdata`=8'h3C on the first transaction; `rdata` unchanged after the write ack.
- Contention:
  - stimulus: `req[1]` and `req[2]` held continuously, each re-asserting after its ack;
  - required: grants alternate 1,2,1,2; no `ack` arrives more than one transaction late.
- Loader priority:
  - stimulus: `req[0]`, `req[1]` and `req[2]` all high in the same cycle;
  - required: loader is served first, then slot 1, then slot 2.
- Reset mid-transaction:
  - stimulus: pull `reset_n` low during WAIT;
  - required: `mem_req`=0 and `busy`=0 immediately; no `ack` is generated; `rdata`=8'hFF.
- Timeout:
  - stimulus: build with `MEGARAM_ARB_TIMEOUT_EN`, `TIMEOUT`=16; memory never acks a read;
  - required: `ack` pulses after 16 WAIT cycles, `rdata`=8'hFF, `err`=1 and stays 1 until reset.

Source files
------------

// File: rtl/megaram_ram_arbiter_pkg.sv
// Shared types and constants for the cartridge-RAM arbiter and its winner picker.
package megaram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  localparam int REQ_LOADER = 0;
  localparam int REQ_SLOT1  = 1;
  localparam int REQ_SLOT2  = 2;
  localparam int N_REQ      = 3;

  typedef logic [1:0] req_idx_t;

  // Watchdog counter never narrower than a byte, wider if the limit needs it.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/megaram_ram_arbiter_if.sv
// Requester and memory-port bundle of the cartridge-RAM arbiter.
interface megaram_ram_arbiter_if
  import megaram_arb_pkg::*;
#(
  parameter int ADDR_W = 27
);

  logic [N_REQ-1:0]  req;
  logic [ADDR_W-1:0] addr [N_REQ];
  logic [N_REQ-1:0]  rnw;
  logic [7:0]        wdata [N_REQ];
  logic [N_REQ-1:0]  ack;
  logic [7:0]        rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rnw;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req, addr, rnw, wdata, mem_ack, mem_rdata,
    output ack, rdata, mem_req, mem_addr, mem_rnw, mem_wdata
  );

  modport master (
    output req, addr, rnw, wdata, mem_ack, mem_rdata,
    input  ack, rdata, mem_req, mem_addr, mem_rnw, mem_wdata
  );

endinterface

// File: rtl/megaram_ram_arbiter_pick.sv
// Combinational winner selection: requester 0 always wins, the rest rotate after last_slot.
module megaram_arb_pick
  import megaram_arb_pkg::*;
#(
  parameter int N = N_REQ
)
(
  input  logic [N-1:0] req,
  input  req_idx_t     last_slot,
  output logic         valid,
  output req_idx_t     idx
);

  int       cand;
  req_idx_t cand_idx;

  // Scan from lowest to highest rotation priority so the closest slot after last_slot wins.
  always_comb begin
    valid    = |req;
    idx      = req_idx_t'(REQ_LOADER);
    cand     = 0;
    cand_idx = '0;
    if (!req[REQ_LOADER]) begin
      for (int k = N - 1; k >= 1; k--) begin
        cand     = ((int'(last_slot) - 1 + k) % (N - 1)) + 1;
        cand_idx = req_idx_t'(cand);
        if (req[cand_idx]) idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/megaram_ram_arbiter.sv
// Shares one cartridge-RAM port between the loader and two mapper slots.
// Optional transaction watchdog and sticky err flag: define MEGARAM_ARB_TIMEOUT_EN.
module megaram_ram_arbiter
  import megaram_arb_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
)
(
  input  logic                  clk,
  input  logic                  reset_n,
  megaram_ram_arbiter_if.slave  bus,
  output logic                  busy,
  output logic                  err
);

  arb_state_t state, state_nxt;
  req_idx_t   gnt, last_slot, pick_idx;
  logic       pick_valid;
  logic       timeout_hit;

  megaram_arb_pick #(.N(N_REQ)) u_pick (
    .req       (bus.req),
    .last_slot (last_slot),
    .valid     (pick_valid),
    .idx       (pick_idx)
  );

`ifdef MEGARAM_ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Counts WAIT cycles; a zero value on entry means TIMEOUT-1 marks the last allowed cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT) && !bus.mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign err         = err_q;
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.mem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    bus.ack = '0;
    for (int i = 0; i < N_REQ; i++)
      bus.ack[i] = (state == DONE) && (gnt == req_idx_t'(i));
  end

  // A dropped req after the grant cannot abort: everything the memory needs is latched here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b1}};
      bus.mem_rnw   <= 1'b1;
      bus.mem_wdata <= 8'h00;
      bus.rdata     <= 8'hFF;
      gnt           <= req_idx_t'(REQ_LOADER);
      last_slot     <= req_idx_t'(REQ_SLOT2);
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt           <= pick_idx;
            bus.mem_addr  <= bus.addr[pick_idx];
            bus.mem_rnw   <= bus.rnw[pick_idx];
            bus.mem_wdata <= bus.wdata[pick_idx];
          end
        end
        ISSUE: bus.mem_req <= 1'b1;
        WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_rnw) bus.rdata <= bus.mem_rdata;
          end else if (timeout_hit) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_rnw) bus.rdata <= 8'hFF;
          end
        end
        DONE: begin
          if (gnt != req_idx_t'(REQ_LOADER)) last_slot <= gnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_megaram_ram_arbiter.sv
// Self-checking bench for megaram_ram_arbiter: scoreboard of expected grants plus a memory responder.
// Define MEGARAM_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=16.
module tb_megaram_ram_arbiter;
  import megaram_arb_pkg::*;

  localparam int ADDR_W = 27;
`ifdef MEGARAM_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 255;
`endif

  typedef struct {
    int                idx;
    logic [ADDR_W-1:0] addr;
    logic              rnw;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic busy;
  logic err;

  megaram_ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  megaram_ram_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  exp_t       sb [$];
  exp_t       mon_e;
  logic [7:0] mem_model [logic [ADDR_W-1:0]];
  int         checks = 0;
  int         errors = 0;
  int         lat = 0;
  bit         mem_respond = 1'b1;
  int         wait_cnt = 0;
  logic       mem_req_prev = 1'b0;
  logic [7:0] last_exp = 8'hFF;

  function automatic logic [7:0] model_read(input logic [ADDR_W-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one held request and record the completion the bench expects for it.
  task automatic applyStimulus(input int r, input logic [ADDR_W-1:0] a, input logic rd,
                               input logic [7:0] wd, input bit no_mem);
    exp_t e;
    bus.addr[r]  = a;
    bus.rnw[r]   = rd;
    bus.wdata[r] = wd;
    bus.req[r]   = 1'b1;
    e.idx   = r;
    e.addr  = a;
    e.rnw   = rd;
    e.wdata = wd;
    if (!rd)         e.rdata = last_exp;
    else if (no_mem) e.rdata = 8'hFF;
    else             e.rdata = model_read(a);
    last_exp = e.rdata;
    sb.push_back(e);
  endtask

  task automatic waitAck(input int r, output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      if (bus.ack[r]) break;
      @(posedge clk);
      cycles++;
    end
    checkOutput($sformatf("ack%0d_within_bound", r), 32'(cycles < 100), 1);
    @(posedge clk); #1;
    bus.req[r] = 1'b0;
  endtask

  task automatic waitAnyAck(output int r);
    int cycles;
    cycles = 0;
    r = -1;
    while (cycles < 100) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        for (int k = 0; k < N_REQ; k++)
          if (bus.ack[k]) r = k;
        break;
      end
      @(posedge clk);
      cycles++;
    end
    checkOutput("any_ack_within_bound", 32'(cycles < 100), 1);
    @(posedge clk); #1;
    if (r >= 0) bus.req[r] = 1'b0;
  endtask

  // Memory model: acks lat cycles after mem_req is seen, returns model data, stores writes.
  always @(negedge clk) begin
    if (!reset_n) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      wait_cnt      = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      wait_cnt      = 0;
    end else if (bus.mem_req && mem_respond) begin
      if (wait_cnt >= lat) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_rnw) begin
          bus.mem_rdata = model_read(bus.mem_addr);
        end else begin
          mem_model[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = 8'hEE;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Scoreboard monitor: checks the latched memory request and every ack against the queue head.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_req && !mem_req_prev) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_mem_req", 32'(bus.mem_req), 0);
        end else begin
          checkOutput("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
          checkOutput("mem_rnw", 32'(bus.mem_rnw), 32'(sb[0].rnw));
          if (!sb[0].rnw) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
        end
      end
      if (bus.ack != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", 32'(bus.ack), 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("ack_grant", 32'(bus.ack), 32'(1) << mon_e.idx);
          checkOutput("ack_rdata", 32'(bus.rdata), 32'(mon_e.rdata));
        end
      end
    end
    mem_req_prev = bus.mem_req;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int  cyc;
    int  r;
    time t_now;
    time t_prev;

    t_prev = 0;
    bus.req = '0;
    bus.rnw = '1;
    for (int k = 0; k < N_REQ; k++) begin
      bus.addr[k]  = '0;
      bus.wdata[k] = 8'h00;
    end
    mem_model[27'h0012345] = 8'hA5;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_mem_req", 32'(bus.mem_req), 0);
    checkOutput("rst_ack", 32'(bus.ack), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_rdata", 32'(bus.rdata), 32'h0FF);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'h7FF_FFFF);
    checkOutput("rst_mem_rnw", 32'(bus.mem_rnw), 1);
    checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single read on slot 1");
    applyStimulus(1, 27'h0012345, 1'b1, 8'h00, 1'b0);
    waitAck(1, cyc);
    checkOutput("read_latency", 32'(cyc), 3);
    checkOutput("read_mem_addr", 32'(bus.mem_addr), 32'h0012345);
    checkOutput("read_rdata", 32'(bus.rdata), 32'h0A5);

    $display("[TB] write then read on slot 2, memory latency 2");
    lat = 2;
    applyStimulus(2, 27'h0100000, 1'b0, 8'h3C, 1'b0);
    waitAck(2, cyc);
    checkOutput("write_latency", 32'(cyc), 5);
    checkOutput("rdata_after_write", 32'(bus.rdata), 32'h0A5);
    applyStimulus(2, 27'h0100000, 1'b1, 8'h00, 1'b0);
    waitAck(2, cyc);
    checkOutput("readback_rdata", 32'(bus.rdata), 32'h03C);
    lat = 0;

    $display("[TB] slot contention");
    applyStimulus(1, 27'h0000111, 1'b1, 8'h00, 1'b0);
    applyStimulus(2, 27'h0000222, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      waitAnyAck(r);
      t_now = $time;
      checkOutput($sformatf("contention_order_%0d", i), 32'(r), (i % 2 == 0) ? 1 : 2);
      if (i > 0) checkOutput($sformatf("contention_interval_%0d", i), 32'((t_now - t_prev) / 10), 4);
      t_prev = t_now;
      if (i < 2) applyStimulus(r, 27'h0000333 + 27'(i), 1'b1, 8'h00, 1'b0);
    end

    $display("[TB] loader priority");
    applyStimulus(0, 27'h7000000, 1'b0, 8'h5A, 1'b0);
    applyStimulus(1, 27'h0000444, 1'b1, 8'h00, 1'b0);
    applyStimulus(2, 27'h0000555, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      waitAnyAck(r);
      checkOutput($sformatf("priority_order_%0d", i), 32'(r), 32'(i));
    end

    $display("[TB] reset during WAIT");
    mem_respond = 1'b0;
    applyStimulus(1, 27'h0000666, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req) break;
    end
    checkOutput("mid_mem_req_seen", 32'(bus.mem_req), 1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_mem_req", 32'(bus.mem_req), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_rdata", 32'(bus.rdata), 32'h0FF);
    checkOutput("mid_rst_ack", 32'(bus.ack), 0);
    sb.delete();
    bus.req[1] = 1'b0;
    last_exp = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      checkOutput("mid_rst_no_ack", 32'(bus.ack), 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_respond = 1'b1;
    @(posedge clk); #1;

    $display("[TB] recovery read");
    applyStimulus(1, 27'h0000777, 1'b1, 8'h00, 1'b0);
    waitAck(1, cyc);
    checkOutput("recover_latency", 32'(cyc), 3);

`ifdef MEGARAM_ARB_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    mem_respond = 1'b0;
    applyStimulus(2, 27'h0000888, 1'b1, 8'h00, 1'b1);
    waitAck(2, cyc);
    checkOutput("timeout_latency", 32'(cyc), 18);
    checkOutput("timeout_mem_req", 32'(bus.mem_req), 0);
    checkOutput("timeout_err", 32'(err), 1);
    mem_respond = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1, 27'h0000999, 1'b1, 8'h00, 1'b0);
    waitAck(1, cyc);
    checkOutput("err_sticky", 32'(err), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("err_cleared_by_reset", 32'(err), 0);
    last_exp = 8'hFF;
    @(posedge clk); #1;
    reset_n = 1'b1;
`else
    checkOutput("err_tied_low", 32'(err), 0);
`endif

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
